// File: rtl/clock_gate_sched_pkg.sv
// clock_gate_sched_pkg
// Shared types and constants for the gated-register scheduler.
//   state_t         : scheduler FSM states (RUN, SLEEP, WAKE), 2-bit encoding
//   DEF_*           : default parameter values used by clock_gate_sched
//   idle_cnt_width  : width of the idle counter needed to reach IDLE_CYCLES
package clock_gate_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 1;
    localparam int DEF_IDLE_CYCLES = 8;
    localparam int DEF_CNT_W       = 16;

    // The counter must be able to hold the value IDLE_CYCLES itself; keep at
    // least one bit so the IDLE_CYCLES=0 build still has a legal vector.
    function automatic int idle_cnt_width(input int idle_cycles);
        if (idle_cycles <= 1) begin
            return 1;
        end
        return $clog2(idle_cycles + 1);
    endfunction

endpackage

// File: rtl/clock_gate_sched_rr_arbiter.sv
// rr_arbiter
// Combinational rotating-priority arbiter. The search starts one position
// after the last granted requester and wraps around.
// Ports:
//   req      in  NUM_REQ  request vector
//   last     in  IDX_W    index of the most recently granted requester
//   gnt      out NUM_REQ  one-hot pick (all zero when req==0)
//   gnt_idx  out IDX_W    index of the pick
//   any_req  out 1        |req
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Offsets 1..NUM_REQ visit every requester once, the last one visited
        // being the previous winner, so it has the lowest priority.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/clock_gate_sched.sv
// clock_gate_sched
// Shares one gated register among NUM_REQ requesters. Write requests are
// arbitrated round-robin; the winner's data and a one-cycle enable are driven
// to the register. After IDLE_CYCLES request-free cycles the scheduler sleeps
// (enable held low) and takes one WAKE cycle before granting again.
// Optional build macro: CLOCK_GATE_SCHED_STATS_EN adds grant_cnt_out, a
// saturating count of issued grants.
// Ports:
//   clk            in  1                 clock, rising edge
//   reset_in       in  1                 synchronous active-high reset
//   req_in         in  NUM_REQ           level request per requester
//   data_in        in  NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//   gnt_out        out NUM_REQ           registered one-hot grant
//   enable_out     out 1                 gated register enable (= |gnt_out)
//   d_out          out DATA_W            gated register data (granted requester)
//   sleep_out      out 1                 high while in SLEEP
//   grant_cnt_out  out CNT_W             grant count (stats build only)
module clock_gate_sched
    import clock_gate_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset_in,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    output logic                      enable_out,
    output logic [DATA_W-1:0]         d_out,
    output logic                      sleep_out
`ifdef CLOCK_GATE_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]          grant_cnt_out
`endif
);

    localparam int                IDX_W        = $clog2(NUM_REQ);
    localparam int                IDLE_W       = idle_cnt_width(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT   = IDLE_W'(IDLE_CYCLES);
    localparam bit                SLEEP_ENABLE = (IDLE_CYCLES != 0);

    state_t              state_reg, state_next;
    logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [IDX_W-1:0]    last_reg, last_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [DATA_W-1:0]   d_reg, d_next;
    logic                sleep_reg, sleep_next;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                any_req;
    logic                issue;
    logic [DATA_W-1:0]   arb_data;
    logic [DATA_W-1:0]   masked_data [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_in),
        .last    (last_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (any_req)
    );

    // One-hot and-or mux of the winner's data slice.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign masked_data[gi] = data_in[gi*DATA_W +: DATA_W] & {DATA_W{arb_gnt[gi]}};
    end

    always_comb begin
        arb_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_data = arb_data | masked_data[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A request on the edge where the idle count would hit
    // the limit keeps the scheduler in RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (!any_req && SLEEP_ENABLE && (idle_cnt_reg + IDLE_W'(1) == IDLE_LIMIT)) begin
                    state_next = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (any_req) begin
                    state_next = ST_WAKE;
                end
            end
            ST_WAKE: state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        issue         = any_req && (state_reg == ST_RUN || state_reg == ST_WAKE);
        gnt_next      = issue ? arb_gnt  : '0;
        d_next        = issue ? arb_data : d_reg;
        last_next     = issue ? arb_idx  : last_reg;
        sleep_next    = (state_next == ST_SLEEP);
        idle_cnt_next = idle_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (any_req) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg != IDLE_LIMIT) begin
                    idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
                end
            end
            ST_WAKE: idle_cnt_next = '0;
            default: idle_cnt_next = idle_cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            idle_cnt_reg <= '0;
            last_reg     <= IDX_W'(NUM_REQ - 1);
            gnt_reg      <= '0;
            d_reg        <= '0;
            sleep_reg    <= 1'b0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            last_reg     <= last_next;
            gnt_reg      <= gnt_next;
            d_reg        <= d_next;
            sleep_reg    <= sleep_next;
        end
    end

    assign gnt_out    = gnt_reg;
    assign enable_out = |gnt_reg;
    assign d_out      = d_reg;
    assign sleep_out  = sleep_reg;

`ifdef CLOCK_GATE_SCHED_STATS_EN
    logic [CNT_W-1:0] grant_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            grant_cnt_reg <= '0;
        end else if (issue && (grant_cnt_reg != '1)) begin
            grant_cnt_reg <= grant_cnt_reg + CNT_W'(1);
        end
    end

    assign grant_cnt_out = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_clock_gate_sched.sv
// tb_clock_gate_sched
// Directed self-checking bench for clock_gate_sched with default parameters
// (NUM_REQ=4, DATA_W=1, IDLE_CYCLES=8). Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, so each step() shows
// the result of the edge that sampled the previously driven inputs.
module tb_clock_gate_sched;

    logic       clk = 1'b0;
    logic       reset_in;
    logic [3:0] req_in;
    logic [3:0] data_in;
    logic [3:0] gnt_out;
    logic       enable_out;
    logic [0:0] d_out;
    logic       sleep_out;
`ifdef CLOCK_GATE_SCHED_STATS_EN
    logic [15:0] grant_cnt_out;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    clock_gate_sched dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .req_in        (req_in),
        .data_in       (data_in),
        .gnt_out       (gnt_out),
        .enable_out    (enable_out),
        .d_out         (d_out),
        .sleep_out     (sleep_out)
`ifdef CLOCK_GATE_SCHED_STATS_EN
        ,
        .grant_cnt_out (grant_cnt_out)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        req_in   = 4'b0000;
        data_in  = 4'b0000;
        step();
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        req_in   = 4'b1111;
        data_in  = 4'b1111;
        repeat (3) step();
        vectors++;
        if (gnt_out !== 4'b0000 || enable_out !== 1'b0 || d_out !== 1'b0 || sleep_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b en=%b d=%b sleep=%b, required 0000 0 0 0",
                     gnt_out, enable_out, d_out, sleep_out);
        end
`ifdef CLOCK_GATE_SCHED_STATS_EN
        vectors++;
        if (grant_cnt_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d, required 0", grant_cnt_out);
        end
`endif
        reset_in = 1'b0;
        step();
        vectors++;
        if (gnt_out !== 4'b0001 || enable_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b en=%b, required 0001 1", gnt_out, enable_out);
        end
        $display("test_reset: done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [0:0] exp_d   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_gnt2 [3] = '{4'b0001, 4'b0100, 4'b0001};
        do_reset();
        req_in  = 4'b1111;
        data_in = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (gnt_out !== exp_gnt[i % 4] || enable_out !== 1'b1 || d_out !== exp_d[i % 4]) begin
                errors++;
                $display("FAIL rr_all[%0d]: gnt=%b en=%b d=%b, required %b 1 %b",
                         i, gnt_out, enable_out, d_out, exp_gnt[i % 4], exp_d[i % 4]);
            end
        end
        // Pointer now sits at requester 3, so requester 0 is next in line.
        req_in  = 4'b0101;
        data_in = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (gnt_out !== exp_gnt2[i] || enable_out !== 1'b1 || d_out !== 1'b1) begin
                errors++;
                $display("FAIL rr_0101[%0d]: gnt=%b en=%b d=%b, required %b 1 1",
                         i, gnt_out, enable_out, d_out, exp_gnt2[i]);
            end
        end
        $display("test_round_robin: done");
    endtask

    task automatic test_sparse();
        // Previous grant was requester 0 with data 1; d_out must hold it.
        req_in  = 4'b0000;
        data_in = 4'b0000;
        step();
        vectors++;
        if (gnt_out !== 4'b0000 || enable_out !== 1'b0 || d_out !== 1'b1) begin
            errors++;
            $display("FAIL sparse_idle_hold: gnt=%b en=%b d=%b, required 0000 0 1", gnt_out, enable_out, d_out);
        end
        data_in = 4'b1011;
        step();
        vectors++;
        if (d_out !== 1'b1 || enable_out !== 1'b0) begin
            errors++;
            $display("FAIL sparse_idle_hold2: en=%b d=%b, required 0 1", enable_out, d_out);
        end
        req_in  = 4'b0100;
        data_in = 4'b0100;
        step();
        vectors++;
        if (gnt_out !== 4'b0100 || enable_out !== 1'b1 || d_out !== 1'b1) begin
            errors++;
            $display("FAIL sparse_grant: gnt=%b en=%b d=%b, required 0100 1 1", gnt_out, enable_out, d_out);
        end
        req_in  = 4'b0000;
        data_in = 4'b0000;
        step();
        vectors++;
        if (gnt_out !== 4'b0000 || enable_out !== 1'b0 || d_out !== 1'b1) begin
            errors++;
            $display("FAIL sparse_after: gnt=%b en=%b d=%b, required 0000 0 1", gnt_out, enable_out, d_out);
        end
        $display("test_sparse: done");
    endtask

    task automatic test_sleep_wake();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            vectors++;
            if (sleep_out !== (i == 8) || enable_out !== 1'b0) begin
                errors++;
                $display("FAIL sleep_entry[%0d]: sleep=%b en=%b, required %b 0", i, sleep_out, enable_out, (i == 8));
            end
        end
        step();
        vectors++;
        if (sleep_out !== 1'b1) begin
            errors++;
            $display("FAIL sleep_stay: sleep=%b, required 1", sleep_out);
        end
        req_in  = 4'b0010;
        data_in = 4'b0010;
        step();
        vectors++;
        if (sleep_out !== 1'b0 || gnt_out !== 4'b0000 || enable_out !== 1'b0) begin
            errors++;
            $display("FAIL wake_cycle: sleep=%b gnt=%b en=%b, required 0 0000 0", sleep_out, gnt_out, enable_out);
        end
        step();
        vectors++;
        if (gnt_out !== 4'b0010 || enable_out !== 1'b1 || d_out !== 1'b1 || sleep_out !== 1'b0) begin
            errors++;
            $display("FAIL wake_grant: gnt=%b en=%b d=%b sleep=%b, required 0010 1 1 0",
                     gnt_out, enable_out, d_out, sleep_out);
        end
        req_in  = 4'b0000;
        data_in = 4'b0000;
        $display("test_sleep_wake: done");
    endtask

    task automatic test_wake_drop();
        do_reset();
        repeat (8) step();
        vectors++;
        if (sleep_out !== 1'b1) begin
            errors++;
            $display("FAIL drop_sleep: sleep=%b, required 1", sleep_out);
        end
        req_in = 4'b0001;
        step();
        req_in = 4'b0000;
        step();
        vectors++;
        if (gnt_out !== 4'b0000 || sleep_out !== 1'b0) begin
            errors++;
            $display("FAIL drop_wake: gnt=%b sleep=%b, required 0000 0", gnt_out, sleep_out);
        end
        // Back in RUN with the idle count at zero: eight more idle edges.
        for (int i = 1; i <= 8; i++) begin
            step();
            vectors++;
            if (sleep_out !== (i == 8)) begin
                errors++;
                $display("FAIL drop_resleep[%0d]: sleep=%b, required %b", i, sleep_out, (i == 8));
            end
        end
        $display("test_wake_drop: done");
    endtask

    task automatic test_boundary();
        do_reset();
        repeat (7) step();
        req_in  = 4'b1000;
        data_in = 4'b1000;
        step();
        vectors++;
        if (sleep_out !== 1'b0 || gnt_out !== 4'b1000 || enable_out !== 1'b1 || d_out !== 1'b1) begin
            errors++;
            $display("FAIL boundary: sleep=%b gnt=%b en=%b d=%b, required 0 1000 1 1",
                     sleep_out, gnt_out, enable_out, d_out);
        end
        req_in  = 4'b0000;
        data_in = 4'b0000;
        $display("test_boundary: done");
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_in  = 4'b1111;
        data_in = 4'b1111;
        step();
        step();
        vectors++;
        if (gnt_out !== 4'b0010 || d_out !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre: gnt=%b d=%b, required 0010 1", gnt_out, d_out);
        end
        reset_in = 1'b1;
        step();
        vectors++;
        if (gnt_out !== 4'b0000 || enable_out !== 1'b0 || d_out !== 1'b0 || sleep_out !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: gnt=%b en=%b d=%b sleep=%b, required 0000 0 0 0",
                     gnt_out, enable_out, d_out, sleep_out);
        end
`ifdef CLOCK_GATE_SCHED_STATS_EN
        vectors++;
        if (grant_cnt_out !== 16'd0) begin
            errors++;
            $display("FAIL midop_cnt_clear: got %0d, required 0", grant_cnt_out);
        end
`endif
        reset_in = 1'b0;
        step();
        vectors++;
        if (gnt_out !== 4'b0001) begin
            errors++;
            $display("FAIL midop_first: gnt=%b, required 0001", gnt_out);
        end
        repeat (3) step();
        vectors++;
        if (gnt_out !== 4'b1000 || enable_out !== 1'b1) begin
            errors++;
            $display("FAIL midop_fourth: gnt=%b en=%b, required 1000 1", gnt_out, enable_out);
        end
`ifdef CLOCK_GATE_SCHED_STATS_EN
        vectors++;
        if (grant_cnt_out !== 16'd4) begin
            errors++;
            $display("FAIL midop_cnt4: got %0d, required 4", grant_cnt_out);
        end
`endif
        req_in = 4'b0000;
        $display("test_reset_mid_op: done");
    endtask

    initial begin
        reset_in = 1'b1;
        req_in   = 4'b0000;
        data_in  = 4'b0000;
        #1;
        test_reset();
        test_round_robin();
        test_sparse();
        test_sleep_wake();
        test_wake_drop();
        test_boundary();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
